// File: rtl/halut_decoder_if.sv
// Code/LUT-write bundle between the encoder stage and one halut_decoder column.
// The master side drives codes and LUT writes; the slave side returns the column result.
interface halut_decoder_if #(
    parameter int unsigned K             = 16,
    parameter int unsigned C             = 32,
    parameter int unsigned DataTypeWidth = 16,
    parameter int unsigned AccWidth      = 32,
    parameter int unsigned TreeDepth     = $clog2(K),
    parameter int unsigned CAddrWidth    = $clog2(C),
    parameter int unsigned LutAddrWidth  = $clog2(C * K)
);
    logic [LutAddrWidth-1:0]  waddr_i;
    logic [DataTypeWidth-1:0] wdata_i;
    logic                     we_i;
    logic                     decoder_i;
    logic [CAddrWidth-1:0]    c_addr_i;
    logic [TreeDepth-1:0]     k_addr_i;
    logic                     valid_i;
    logic [AccWidth-1:0]      result_o;
    logic                     valid_o;

    modport master (
        output waddr_i, wdata_i, we_i, decoder_i, c_addr_i, k_addr_i, valid_i,
        input  result_o, valid_o
    );

    modport slave (
        input  waddr_i, wdata_i, we_i, decoder_i, c_addr_i, k_addr_i, valid_i,
        output result_o, valid_o
    );
endinterface

// File: rtl/halut_decoder.sv
// HALUT decoder column: looks up one LUT entry per (c, k) code and accumulates C of them
// into a signed dot-product result, pulsing valid_o once per completed frame.
module halut_decoder #(
    parameter int unsigned K             = 16,
    parameter int unsigned C             = 32,
    parameter int unsigned DataTypeWidth = 16,
    parameter int unsigned AccWidth      = 32,
    parameter int unsigned TreeDepth     = $clog2(K),
    parameter int unsigned CAddrWidth    = $clog2(C),
    parameter int unsigned LutAddrWidth  = $clog2(C * K)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    halut_decoder_if.slave bus
);
    localparam int unsigned Entries = C * K;

    logic [DataTypeWidth-1:0] r_lut [Entries];
    logic [LutAddrWidth-1:0]  r_addr;
    logic                     r_v1;
    logic [CAddrWidth-1:0]    r_cnt;
    logic [AccWidth-1:0]      r_acc;
    logic [AccWidth-1:0]      r_result;
    logic                     r_valid;

    logic [DataTypeWidth-1:0] w_entry;
    logic [AccWidth-1:0]      w_entry_ext;
    logic [AccWidth-1:0]      w_sum;
    logic                     w_accept;
    logic                     w_last;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lut <= '{default: '0};
        end else if (bus.we_i) begin
            r_lut[bus.waddr_i] <= bus.wdata_i;
        end
    end

    // The read sees the pre-edge LUT contents, so a same-edge write to this address sums the old value.
    assign w_entry     = r_lut[r_addr];
    assign w_entry_ext = {{(AccWidth - DataTypeWidth){w_entry[DataTypeWidth-1]}}, w_entry};
    assign w_sum       = r_acc + w_entry_ext;
    assign w_accept    = bus.decoder_i && bus.valid_i;
    assign w_last      = r_v1 && (r_cnt == CAddrWidth'(C - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_v1   <= 1'b0;
            r_addr <= '0;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_addr <= LutAddrWidth'({bus.c_addr_i, bus.k_addr_i});
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!bus.decoder_i) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_last) begin
                r_result <= w_sum;
                r_valid  <= 1'b1;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (r_v1) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CAddrWidth'(1);
            end
        end
    end

    assign bus.result_o = r_result;
    assign bus.valid_o  = r_valid;
endmodule
